updown_gray_counter: RTL and testbench
======================================

// Module: updown_gray_counter
// PURPOSE
//   Parametrised up/down state counter; next generation of the 3-bit A-driven
//   Y1..Y3 state machine. Adds width, Gray or binary output coding, wrap or
//   saturate mode, enable, synchronous load and a terminal-count flag.
//   Present and next state stay visible on ports for bench/waveform debug.
//   Used standalone in exercise benches and as a sequencer inside larger FSMs.
// PARAMETERS
//   WIDTH     3   state/output width in bits (>=2)
//   GRAY_OUT  1   1: y is Gray-coded state; 0: y is binary state
//   SATURATE  0   0: wrap modulo 2^WIDTH; 1: stop at MAX (up) / 0 (down)
// PORTS
//   clk       in   1      clock, rising edge
//   reset     in   1      asynchronous, active-low reset (0 = in reset)
//   en        in   1      count enable
//   dir       in   1      0 = count up, 1 = count down
//   load      in   1      synchronous load strobe
//   load_val  in   WIDTH  load value, always binary regardless of GRAY_OUT
//   y         out  WIDTH  coded output (Gray or binary per GRAY_OUT)
//   s_pres    out  WIDTH  present state, binary (registered)
//   s_fut     out  WIDTH  next state, binary (combinational)
//   tc        out  1      terminal count: counting step at boundary this cycle
// BEHAVIOUR
// - State: one WIDTH-bit binary register s_pres. MAX = 2^WIDTH-1.
// - Reset (reset=0): s_pres=0 immediately, no clock edge needed. While in
//   reset: y=0, s_fut=0, tc=0. First update is the first rising edge after
//   reset returns to 1.
// - s_fut priority, evaluated each cycle:
//     load=1          -> load_val (en and dir ignored)
//     en=1, dir=0     -> s_pres+1
//     en=1, dir=1     -> s_pres-1
//     en=0, load=0    -> s_pres (hold)
// - Boundary: SATURATE=0: MAX+1 -> 0 and 0-1 -> MAX, modulo WIDTH bits.
//   SATURATE=1: up at MAX holds MAX; down at 0 holds 0.
// - s_pres <= s_fut on every rising edge. Latency 1: an input sampled on
//   edge k is visible on s_pres/y after edge k.
// - y = GRAY_OUT ? (s_pres ^ (s_pres>>1)) : s_pres. Derived from s_pres
//   only, so y changes only at clock edges or reset. With GRAY_OUT=1 and
//   SATURATE=0, consecutive counted values differ in exactly one bit,
//   wrap included. A load may change several bits.
// - tc = reset & en & ~load & ((~dir & s_pres==MAX) | (dir & s_pres==0)).
//   It is combinational and asserted in the cycle before the wrap or
//   saturate edge. In SATURATE=1 it stays high while held at the boundary
//   with en=1.
// - Direction change mid-count: the new dir applies at the next edge, with
//   no dead cycle. Example: up 3->4, dir flips, next edge 4->3.
// - load and en both high: load wins. tc=0 in that cycle.
// - reset falling between edges during a count: state clears at once. The
//   pending step is lost and no tc pulse is generated.
// TESTING (WIDTH=3 unless noted; release reset 1->0->1 at t=1..2)
// 1 Reset, then en=1, dir=0, 9 edges -> y: 000,001,011,010,110,111,101,100,000;
//   s_pres 0..7,0; tc=1 only while s_pres=7.
// 2 From s_pres=0: en=1, dir=1 -> tc=1 before edge; after edge s_pres=7,
//   y=100, s_fut shows 6.
// 3 s_pres=2, load=1, load_val=5, en=1, dir=1 -> after edge s_pres=5,
//   y=111; tc=0 during load cycle.
// 4 SATURATE=1: start at 6, en=1, dir=0, 4 edges -> s_pres 7,7,7,7;
//   tc=1 from s_pres=7 on. dir=1 then steps 7->6.
// 5 Count to s_pres=4, drop reset mid-cycle (no edge) -> s_pres=0, y=0,
//   tc=0 immediately. Release -> count resumes 0->1.
// 6 en=0, load=0, dir toggled every cycle for 5 edges -> s_pres, y and
//   s_fut constant. GRAY_OUT=0 instance, test 1 -> y equals s_pres.

Source files
------------

// File: rtl/updown_gray_counter.sv
// Parametrised up/down state counter with Gray or binary output coding,
// wrap or saturate boundary handling, enable, synchronous load and terminal count.
module updown_gray_counter #(
  parameter int unsigned WIDTH    = 3,
  parameter int unsigned GRAY_OUT = 1,
  parameter int unsigned SATURATE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] s_pres,
  output logic [WIDTH-1:0] s_fut,
  output logic             tc
);

  localparam logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO_VAL = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_VAL  = WIDTH'(1);

  logic [WIDTH-1:0] s_pres_q;
  logic [WIDTH-1:0] s_pres_d;
  logic [WIDTH-1:0] y_q;
  logic             tc_c;
  logic             at_max;
  logic             at_zero;

  // Output coding applied to the next state so y lands together with s_pres.
  function automatic logic [WIDTH-1:0] encode(input logic [WIDTH-1:0] v);
    if (GRAY_OUT != 0) begin
      encode = v ^ (v >> 1);
    end else begin
      encode = v;
    end
  endfunction

  assign at_max  = (s_pres_q == MAX_VAL);
  assign at_zero = (s_pres_q == ZERO_VAL);

  // Next-state priority: reset, load, count, hold.
  always_comb begin
    s_pres_d = s_pres_q;
    tc_c     = 1'b0;
    if (!reset) begin
      s_pres_d = ZERO_VAL;
    end else if (load) begin
      s_pres_d = load_val;
    end else if (en) begin
      if (!dir) begin
        if (at_max) begin
          tc_c     = 1'b1;
          s_pres_d = (SATURATE != 0) ? MAX_VAL : ZERO_VAL;
        end else begin
          s_pres_d = s_pres_q + ONE_VAL;
        end
      end else begin
        if (at_zero) begin
          tc_c     = 1'b1;
          s_pres_d = (SATURATE != 0) ? ZERO_VAL : MAX_VAL;
        end else begin
          s_pres_d = s_pres_q - ONE_VAL;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_pres_q <= ZERO_VAL;
      y_q      <= ZERO_VAL;
    end else begin
      s_pres_q <= s_pres_d;
      y_q      <= encode(s_pres_d);
    end
  end

  assign s_pres = s_pres_q;
  assign y      = y_q;
  assign s_fut  = s_pres_d;
  assign tc     = tc_c;

endmodule

// File: tb/tb_updown_gray_counter.sv
// Scoreboard bench for updown_gray_counter: Gray/wrap, binary/wrap and
// Gray/saturate instances share stimulus and are checked against a reference model.
module tb_updown_gray_counter;

  logic       clk;
  logic       reset;
  logic       en;
  logic       dir;
  logic       load;
  logic [2:0] load_val;

  logic [2:0] y_gw, sp_gw, sf_gw;
  logic [2:0] y_bw, sp_bw, sf_bw;
  logic [2:0] y_gs, sp_gs, sf_gs;
  logic       tc_gw, tc_bw, tc_gs;

  updown_gray_counter #(.WIDTH(3), .GRAY_OUT(1), .SATURATE(0)) u_gw (
    .clk(clk), .reset(reset), .en(en), .dir(dir), .load(load), .load_val(load_val),
    .y(y_gw), .s_pres(sp_gw), .s_fut(sf_gw), .tc(tc_gw));

  updown_gray_counter #(.WIDTH(3), .GRAY_OUT(0), .SATURATE(0)) u_bw (
    .clk(clk), .reset(reset), .en(en), .dir(dir), .load(load), .load_val(load_val),
    .y(y_bw), .s_pres(sp_bw), .s_fut(sf_bw), .tc(tc_bw));

  updown_gray_counter #(.WIDTH(3), .GRAY_OUT(1), .SATURATE(1)) u_gs (
    .clk(clk), .reset(reset), .en(en), .dir(dir), .load(load), .load_val(load_val),
    .y(y_gs), .s_pres(sp_gs), .s_fut(sf_gs), .tc(tc_gs));

  typedef struct {
    int sp_w; int y_gw; int y_bw; int sf_w; int tc_w;
    int sp_s; int y_s;  int sf_s; int tc_s;
  } exp_t;

  exp_t q[$];
  int   n_total = 0;
  int   n_pass  = 0;
  bit   done    = 0;
  int   mw;   // model state, wrapping counter
  int   ms;   // model state, saturating counter
  int   gray_tab [8] = '{0, 1, 3, 2, 6, 7, 5, 4};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int nxt(int s, bit sat, bit rst_n, bit e, bit d, bit l, int lv);
    if (!rst_n) return 0;
    if (l) return lv;
    if (!e) return s;
    if (!d) return sat ? ((s == 7) ? 7 : s + 1) : (s + 1) % 8;
    return sat ? ((s == 0) ? 0 : s - 1) : (s + 7) % 8;
  endfunction

  function automatic int tcm(int s, bit rst_n, bit e, bit d, bit l);
    return (rst_n && e && !l && ((!d && s == 7) || (d && s == 0))) ? 1 : 0;
  endfunction

  task automatic push_exp();
    exp_t e;
    e.sp_w = mw;
    e.y_gw = gray_tab[mw];
    e.y_bw = mw;
    e.sf_w = nxt(mw, 1'b0, reset, en, dir, load, int'(load_val));
    e.tc_w = tcm(mw, reset, en, dir, load);
    e.sp_s = ms;
    e.y_s  = gray_tab[ms];
    e.sf_s = nxt(ms, 1'b1, reset, en, dir, load, int'(load_val));
    e.tc_s = tcm(ms, reset, en, dir, load);
    q.push_back(e);
  endtask

  // Advance model over the edge, then apply new inputs and record expectation.
  task automatic step(input bit e, input bit d, input bit l, input int lv);
    @(posedge clk);
    mw = nxt(mw, 1'b0, reset, en, dir, load, int'(load_val));
    ms = nxt(ms, 1'b1, reset, en, dir, load, int'(load_val));
    #1;
    en = e; dir = d; load = l; load_val = 3'(lv);
    push_exp();
  endtask

  // Reset asserted between edges, released before the next edge.
  task automatic rst_pulse();
    @(posedge clk);
    mw = nxt(mw, 1'b0, reset, en, dir, load, int'(load_val));
    ms = nxt(ms, 1'b1, reset, en, dir, load, int'(load_val));
    #1;
    reset = 1'b0;
    mw = 0;
    ms = 0;
    push_exp();
    #6;
    reset = 1'b1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Monitor: pops one expectation per cycle and compares at the falling edge.
  initial begin
    exp_t e;
    while (!done) begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("gw_s_pres", int'(sp_gw), e.sp_w);
        chk("gw_y",      int'(y_gw),  e.y_gw);
        chk("gw_s_fut",  int'(sf_gw), e.sf_w);
        chk("gw_tc",     int'(tc_gw), e.tc_w);
        chk("bw_s_pres", int'(sp_bw), e.sp_w);
        chk("bw_y",      int'(y_bw),  e.y_bw);
        chk("gs_s_pres", int'(sp_gs), e.sp_s);
        chk("gs_y",      int'(y_gs),  e.y_s);
        chk("gs_s_fut",  int'(sf_gs), e.sf_s);
        chk("gs_tc",     int'(tc_gs), e.tc_s);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; en = 1'b1; dir = 1'b0; load = 1'b0; load_val = 3'd0;
    mw = 0; ms = 0;
    #1;
    push_exp();
    #11;
    reset = 1'b1;
    en    = 1'b0;

    // Wrap-around count up through all codes.
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 1'b0, 0);
    // Down from zero wraps to max.
    step(1'b1, 1'b1, 1'b0, 0);
    step(1'b1, 1'b1, 1'b0, 0);
    // Load beats count.
    step(1'b0, 1'b0, 1'b1, 2);
    step(1'b1, 1'b1, 1'b1, 5);
    step(1'b0, 1'b0, 1'b0, 0);
    // Saturation at max, then reverse.
    step(1'b0, 1'b0, 1'b1, 6);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 0);
    step(1'b1, 1'b1, 1'b0, 0);
    step(1'b1, 1'b1, 1'b0, 0);
    // Direction flip without dead cycle.
    step(1'b0, 1'b0, 1'b1, 3);
    step(1'b1, 1'b0, 1'b0, 0);
    step(1'b1, 1'b1, 1'b0, 0);
    step(1'b1, 1'b0, 1'b0, 0);
    // Mid-cycle reset, then resume counting.
    rst_pulse();
    step(1'b1, 1'b0, 1'b0, 0);
    step(1'b1, 1'b0, 1'b0, 0);
    // Hold with dir toggling.
    for (int i = 0; i < 5; i++) step(1'b0, 1'(i % 2), 1'b0, 0);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 39) == 0) rst_pulse();
      else step(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 7) == 0), int'($urandom_range(0, 7)));
    end

    repeat (2) @(posedge clk);
    done = 1'b1;
    n_total++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
